// File: rtl/gol_run_scheduler.sv
// Game-of-Life run scheduler: turns keyboard levels into load/clear/generation handshakes
// and paces generations at GEN_HZ. Define GOL_SINGLE_STEP_EN to enable single-step from PAUSED.
module gol_run_scheduler #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int GEN_HZ    = 10,
    parameter int FILE_ID_W = 16,
    parameter int GEN_CNT_W = 16
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 start_lvl,
    input  logic                 pause_lvl,
    input  logic                 clear_lvl,
    input  logic                 step_lvl,
    input  logic [FILE_ID_W-1:0] file_id,
    output logic                 load_req,
    output logic [FILE_ID_W-1:0] load_id,
    input  logic                 load_done,
    output logic                 clear_req,
    input  logic                 clear_done,
    output logic                 gen_req,
    input  logic                 gen_done,
    output logic                 running,
    output logic                 busy,
    output logic [GEN_CNT_W-1:0] gen_count
);

    // TICK_DIV must be at least 2 for the pacing counter to be meaningful.
    localparam int TICK_DIV = CLK_HZ / GEN_HZ;
    localparam int TICK_W   = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

`ifdef GOL_SINGLE_STEP_EN
    localparam logic STEP_EN = 1'b1;
`else
    localparam logic STEP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_RUN,
        S_GEN,
        S_PAUSED
    } state_t;

    state_t                 state_q, state_d;
    logic [TICK_W-1:0]      tick_q, tick_d;
    logic [FILE_ID_W-1:0]   load_id_q, load_id_d;
    logic [GEN_CNT_W-1:0]   gen_count_q, gen_count_d;
    logic                   pend_pause_q, pend_pause_d;
    logic                   pend_clear_q, pend_clear_d;
    logic                   stepped_q, stepped_d;
    logic                   start_q, pause_q, clear_q, step_q;
    logic                   load_req_q, clear_req_q, gen_req_q;
    logic                   running_q, busy_q;

    logic start_ev, pause_ev, clear_ev, step_ev;
    logic pc_eff, pp_eff;

    assign start_ev = start_lvl & ~start_q;
    assign pause_ev = pause_lvl & ~pause_q;
    assign clear_ev = clear_lvl & ~clear_q;
    assign step_ev  = STEP_EN & step_lvl & ~step_q;

    // Commands that arrive in the same cycle as gen_done still count toward the exit decision.
    assign pc_eff = pend_clear_q | clear_ev;
    assign pp_eff = pend_pause_q | pause_ev;

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        load_id_d    = load_id_q;
        gen_count_d  = gen_count_q;
        pend_pause_d = pend_pause_q;
        pend_clear_d = pend_clear_q;
        stepped_d    = stepped_q;
        case (state_q)
            S_IDLE: begin
                if (clear_ev) begin
                    state_d = S_CLEAR;
                end else if (start_ev) begin
                    state_d   = S_LOAD;
                    load_id_d = file_id;
                end
            end
            S_CLEAR: begin
                if (clear_req_q && clear_done) begin
                    state_d     = S_IDLE;
                    gen_count_d = '0;
                end
            end
            S_LOAD: begin
                if (load_req_q && load_done) begin
                    state_d     = S_RUN;
                    gen_count_d = '0;
                    tick_d      = '0;
                end
            end
            S_RUN: begin
                if (clear_ev) begin
                    state_d = S_CLEAR;
                end else if (pause_ev) begin
                    state_d = S_PAUSED;
                end else if (tick_q == TICK_LAST) begin
                    state_d = S_GEN;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_GEN: begin
                pend_clear_d = pc_eff;
                pend_pause_d = pp_eff;
                if (gen_req_q && gen_done) begin
                    gen_count_d  = gen_count_q + 1'b1;
                    tick_d       = '0;
                    pend_clear_d = 1'b0;
                    pend_pause_d = 1'b0;
                    stepped_d    = 1'b0;
                    if (pc_eff)
                        state_d = S_CLEAR;
                    else if (pp_eff || stepped_q)
                        state_d = S_PAUSED;
                    else
                        state_d = S_RUN;
                end
            end
            S_PAUSED: begin
                if (clear_ev) begin
                    state_d = S_CLEAR;
                end else if (start_ev) begin
                    if (file_id == load_id_q) begin
                        state_d = S_RUN;
                        tick_d  = '0;
                    end else begin
                        state_d   = S_LOAD;
                        load_id_d = file_id;
                    end
                end else if (step_ev) begin
                    state_d   = S_GEN;
                    stepped_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tick_q       <= '0;
            load_id_q    <= '0;
            gen_count_q  <= '0;
            pend_pause_q <= 1'b0;
            pend_clear_q <= 1'b0;
            stepped_q    <= 1'b0;
            start_q      <= 1'b0;
            pause_q      <= 1'b0;
            clear_q      <= 1'b0;
            step_q       <= 1'b0;
            load_req_q   <= 1'b0;
            clear_req_q  <= 1'b0;
            gen_req_q    <= 1'b0;
            running_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            load_id_q    <= load_id_d;
            gen_count_q  <= gen_count_d;
            pend_pause_q <= pend_pause_d;
            pend_clear_q <= pend_clear_d;
            stepped_q    <= stepped_d;
            start_q      <= start_lvl;
            pause_q      <= pause_lvl;
            clear_q      <= clear_lvl;
            step_q       <= step_lvl;
            load_req_q   <= (state_d == S_LOAD);
            clear_req_q  <= (state_d == S_CLEAR);
            gen_req_q    <= (state_d == S_GEN);
            running_q    <= (state_d == S_RUN) || (state_d == S_GEN);
            busy_q       <= (state_d == S_CLEAR) || (state_d == S_LOAD) || (state_d == S_GEN);
        end
    end

    assign load_req  = load_req_q;
    assign load_id   = load_id_q;
    assign clear_req = clear_req_q;
    assign gen_req   = gen_req_q;
    assign running   = running_q;
    assign busy      = busy_q;
    assign gen_count = gen_count_q;

endmodule
